wb_write_queue: RTL and testbench

- Small in-order FIFO of pending register writes (destination, data), placed directly upstream of the register file's single write port.
- Lets the writeback stage retire results in bursts without stalling the pipeline.
- Drains one entry per cycle into the register file.
- Exposes a pending-destination scoreboard and youngest-match forwarding for the two register-file read ports, so decode never sees stale data while a write is still queued.

---
 rtl/wb_write_queue_if.sv | 38 +++
 rtl/wb_write_queue.sv | 101 ++++++++++
 tb/tb_wb_write_queue.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/wb_write_queue_if.sv
// Bus between the writeback stage, the register file write/read ports and the write queue.
interface wb_write_queue_if #(
  parameter int WordLen   = 32,
  parameter int WordCount = 16,
  parameter int Depth     = 4
);
  localparam int IW = $clog2(WordCount);
  localparam int CW = $clog2(Depth) + 1;

  logic                 inValid;
  logic [IW-1:0]        inDest;
  logic [WordLen-1:0]   inData;
  logic                 inReady;
  logic                 drainHold;
  logic                 regWrite;
  logic [IW-1:0]        writeRegister;
  logic [WordLen-1:0]   writeData;
  logic [IW-1:0]        src1;
  logic [IW-1:0]        src2;
  logic                 hit1;
  logic                 hit2;
  logic [WordLen-1:0]   fwdData1;
  logic [WordLen-1:0]   fwdData2;
  logic [WordCount-1:0] pending;
  logic [CW-1:0]        count;

  modport master (
    output inValid, inDest, inData, drainHold, src1, src2,
    input  inReady, regWrite, writeRegister, writeData,
           hit1, hit2, fwdData1, fwdData2, pending, count
  );

  modport slave (
    input  inValid, inDest, inData, drainHold, src1, src2,
    output inReady, regWrite, writeRegister, writeData,
           hit1, hit2, fwdData1, fwdData2, pending, count
  );
endinterface

// File: rtl/wb_write_queue.sv
// In-order queue of pending register writes ahead of the register file write port,
// with a pending-destination scoreboard and youngest-match forwarding for two read ports.
module wb_write_queue #(
  parameter int WordLen   = 32,
  parameter int WordCount = 16,
  parameter int Depth     = 4
) (
  input  logic             clk,
  input  logic             rst,
  wb_write_queue_if.slave  bus
);
  localparam int IW = $clog2(WordCount);
  localparam int PW = $clog2(Depth);
  localparam int CW = PW + 1;
  localparam int NP = 2;

  logic [Depth-1:0]              r_vld;
  logic [Depth-1:0][IW-1:0]      r_dest;
  logic [Depth-1:0][WordLen-1:0] r_data;
  logic [PW-1:0]                 r_head;
  logic [PW-1:0]                 r_tail;
  logic [CW-1:0]                 r_count;

  logic                          w_full;
  logic                          w_empty;
  logic                          w_push;
  logic                          w_pop;
  logic [NP-1:0][IW-1:0]         w_src;
  logic [NP-1:0]                 w_hit;
  logic [NP-1:0][WordLen-1:0]    w_fwd;
  logic [WordCount-1:0]          w_pending;

  assign w_full  = (r_count == CW'(Depth));
  assign w_empty = (r_count == '0);
  // inReady depends only on state, so a same-cycle pop never frees a slot early
  assign w_push  = bus.inValid && !w_full;
  assign w_pop   = !w_empty && !bus.drainHold;
  assign w_src   = {bus.src2, bus.src1};

  assign bus.inReady       = !w_full;
  assign bus.regWrite      = w_pop;
  assign bus.writeRegister = r_dest[r_head];
  assign bus.writeData     = r_data[r_head];
  assign bus.hit1          = w_hit[0];
  assign bus.hit2          = w_hit[1];
  assign bus.fwdData1      = w_fwd[0];
  assign bus.fwdData2      = w_fwd[1];
  assign bus.pending       = w_pending;
  assign bus.count         = r_count;

  // Walk entries oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_hit     = '0;
    w_fwd     = '0;
    w_pending = '0;
    for (int k = 0; k < Depth; k++) begin
      logic [PW-1:0] idx;
      idx = r_head + PW'(k);
      if (r_vld[idx]) begin
        w_pending[r_dest[idx]] = 1'b1;
        for (int p = 0; p < NP; p++) begin
          if (r_dest[idx] == w_src[p]) begin
            w_hit[p] = 1'b1;
            w_fwd[p] = r_data[idx];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (w_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload needs no reset: it is only observed through valid bits or while regWrite=1.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_dest[r_tail] <= bus.inDest;
      r_data[r_tail] <= bus.inData;
    end
  end
endmodule

// File: tb/tb_wb_write_queue.sv
// Scoreboard bench for wb_write_queue: directed scenarios plus random traffic.
module tb_wb_write_queue;
  localparam int WL = 32;
  localparam int WC = 16;
  localparam int DP = 4;

  typedef struct {
    logic [3:0]  d;
    logic [31:0] v;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;
  bit   mon_en = 1'b1;

  ent_t mq[$];   // reference queue contents
  ent_t sb[$];   // expected register-file writes, in order

  wb_write_queue_if #(.WordLen(WL), .WordCount(WC), .Depth(DP)) bus ();

  wb_write_queue #(.WordLen(WL), .WordCount(WC), .Depth(DP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: accept when not full, drain head when non-empty and not held.
  always @(posedge clk) begin
    if (!rst) begin
      bit   rw, acc;
      ent_t e;
      rw  = (mq.size() > 0) && !bus.drainHold;
      acc = bus.inValid && (mq.size() < DP);
      if (rw) void'(mq.pop_front());
      if (acc) begin
        e.d = bus.inDest;
        e.v = bus.inData;
        mq.push_back(e);
        sb.push_back(e);
      end
    end
  end

  // Monitor: compare all outputs mid-cycle, when the register file would capture.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      logic [WC-1:0] ep;
      logic          eh1, eh2;
      logic [31:0]   ef1, ef2;
      ent_t          e;
      ep = '0; eh1 = 0; eh2 = 0; ef1 = '0; ef2 = '0;
      foreach (mq[i]) begin
        ep[mq[i].d] = 1'b1;
        if (mq[i].d == bus.src1) begin eh1 = 1; ef1 = mq[i].v; end
        if (mq[i].d == bus.src2) begin eh2 = 1; ef2 = mq[i].v; end
      end
      chk("count",    64'(bus.count),   64'(mq.size()));
      chk("inReady",  64'(bus.inReady), 64'(mq.size() < DP));
      chk("regWrite", 64'(bus.regWrite), 64'((mq.size() > 0) && !bus.drainHold));
      chk("pending",  64'(bus.pending), 64'(ep));
      chk("hit1",     64'(bus.hit1),    64'(eh1));
      chk("fwdData1", 64'(bus.fwdData1), 64'(ef1));
      chk("hit2",     64'(bus.hit2),    64'(eh2));
      chk("fwdData2", 64'(bus.fwdData2), 64'(ef2));
      if (bus.regWrite) begin
        if (sb.size() == 0) chk("unexpected_write", 64'(1), 64'(0));
        else begin
          e = sb.pop_front();
          chk("writeRegister", 64'(bus.writeRegister), 64'(e.d));
          chk("writeData",     64'(bus.writeData),     64'(e.v));
        end
      end
    end
  end

  task automatic drv(input logic v, input logic [3:0] d, input logic [31:0] dat,
                     input logic h, input logic [3:0] s1, input logic [3:0] s2);
    bus.inValid   = v;
    bus.inDest    = d;
    bus.inData    = dat;
    bus.drainHold = h;
    bus.src1      = s1;
    bus.src2      = s2;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.inValid = 0; bus.inDest = '0; bus.inData = '0;
    bus.drainHold = 0; bus.src1 = '0; bus.src2 = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) drv(0, 0, 0, 0, 3, 9);

    // Fill with drainHold, then check full state
    drv(1, 3, 32'h11, 1, 3, 9);
    drv(1, 5, 32'h22, 1, 3, 9);
    drv(1, 3, 32'h33, 1, 3, 9);
    drv(1, 7, 32'h44, 1, 3, 9);
    drv(0, 0, 0, 1, 3, 9);
    chk("full_pending", 64'(bus.pending), 64'h00A8);
    chk("full_fwd1",    64'(bus.fwdData1), 64'h33);

    // Drain four entries with no pushes
    repeat (5) drv(0, 0, 0, 0, 3, 5);

    // Steady stream
    for (int i = 0; i < 8; i++) drv(1, 4'(i), 32'h100 + i, 0, 4'(i), 4'(i + 1));
    drv(0, 0, 0, 0, 0, 1);

    // Full queue while popping: R1 offered until accepted
    for (int i = 0; i < 4; i++) drv(1, 4'(8 + i), 32'h200 + i, 1, 1, 8);
    drv(1, 1, 32'hFF, 0, 1, 8);
    drv(1, 1, 32'hFF, 0, 1, 8);
    repeat (6) drv(0, 0, 0, 0, 1, 8);

    // Async reset mid-cycle with three entries queued
    drv(1, 2, 32'hA1, 1, 2, 6);
    drv(1, 6, 32'hA2, 1, 2, 6);
    drv(1, 2, 32'hA3, 1, 2, 6);
    bus.inValid = 0; bus.drainHold = 0;
    #2;
    chk("pre_rst_regWrite", 64'(bus.regWrite), 64'(1));
    chk("pre_rst_count",    64'(bus.count),    64'(3));
    rst = 1'b1;
    mq.delete();
    sb.delete();
    #1;
    chk("rst_regWrite", 64'(bus.regWrite), 64'(0));
    chk("rst_count",    64'(bus.count),    64'(0));
    chk("rst_pending",  64'(bus.pending),  64'(0));
    chk("rst_hit1",     64'(bus.hit1),     64'(0));
    chk("rst_inReady",  64'(bus.inReady),  64'(1));
    @(posedge clk); #1;
    @(negedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;
    repeat (4) drv(0, 0, 0, 0, 2, 6);

    // Random traffic with frequent destination collisions
    for (int i = 0; i < 400; i++)
      drv($urandom_range(0, 3) != 0, 4'($urandom_range(0, 7)), $urandom,
          $urandom_range(0, 3) == 0, 4'($urandom_range(0, 8)), 4'($urandom_range(0, 8)));

    repeat (6) drv(0, 0, 0, 0, 0, 0);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
